// File: rtl/mic1_pkg.sv
// mic1_pkg: shared types and constants for the MIC-1 register bank
package mic1_pkg;
    localparam int MIC1_WORD_W = 32;
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE} rb_state_t;
    localparam int MAR = 0;
    localparam int MDR = 1;
    localparam int PC  = 2;
    localparam int MBR = 3;
    localparam int SP  = 4;
    localparam int LV  = 5;
    localparam int CPP = 6;
    localparam int TOS = 7;
    localparam int OPC = 8;
    localparam int H   = 9;
endpackage

// File: rtl/mic1_reg_bank_if.sv
// mic1_reg_bank_if: C-bus, B-bus, flat view and save/restore handshake of the register bank
interface mic1_reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    localparam int SEL_W = $clog2(NREGS);
    logic [WIDTH-1:0]       c_bus;
    logic [NREGS-1:0]       wr_mask;
    logic [SEL_W-1:0]       b_sel;
    logic                   b_en;
    logic [WIDTH-1:0]       b_bus;
    logic [NREGS*WIDTH-1:0] all_regs;
    logic                   save_req;
    logic                   restore_req;
    logic                   busy;
    logic                   done;
    modport master (
        output c_bus, wr_mask, b_sel, b_en, save_req, restore_req,
        input  b_bus, all_regs, busy, done
    );
    modport slave (
        input  c_bus, wr_mask, b_sel, b_en, save_req, restore_req,
        output b_bus, all_regs, busy, done
    );
endinterface

// File: rtl/mic1_reg_copy_fsm.sv
// mic1_reg_copy_fsm: sequences one-register-per-cycle copies between live and shadow banks
module mic1_reg_copy_fsm
    import mic1_pkg::*;
#(
    parameter int NREGS = 16,
    localparam int SEL_W = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             saveReq,
    input  logic             restoreReq,
    output logic             busy,
    output logic             done,
    output logic [SEL_W-1:0] idx,
    output logic             saveStb,
    output logic             restoreStb
);
    rb_state_t        state, stateNext;
    logic [SEL_W-1:0] idxNext;
    logic             doneNext, last;

    // state, copy index and completion pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            done  <= doneNext;
        end
    end

    // save has priority over restore; a copy ends after the last index
    always_comb begin
        last      = idx == SEL_W'(NREGS - 1);
        stateNext = state == IDLE ? (saveReq ? SAVE : restoreReq ? RESTORE : IDLE)
                                  : (last ? IDLE : state);
        idxNext   = (state != IDLE && !last) ? idx + 1'b1 : '0;
        doneNext  = state != IDLE && last;
    end

    // copy strobes follow the current state
    always_comb begin
        busy       = state != IDLE;
        saveStb    = state == SAVE;
        restoreStb = state == RESTORE;
    end
endmodule

// File: rtl/mic1_reg_bank.sv
// mic1_reg_bank: NREGS x WIDTH register bank with masked C-bus writes, B-bus read and shadow save/restore
// Optional MIC1_REG_BANK_TRISTATE_EN: b_bus floats instead of driving 0 when not selected
module mic1_reg_bank
    import mic1_pkg::*;
#(
    parameter int WIDTH = MIC1_WORD_W,
    parameter int NREGS = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int SEL_W = $clog2(NREGS)
) (
    input logic            clock,
    input logic            reset,
    mic1_reg_bank_if.slave bus
);
    logic [WIDTH-1:0] regs   [NREGS];
    logic [WIDTH-1:0] shadow [NREGS];
    logic [SEL_W-1:0] idx;
    logic             busy, saveStb, restoreStb, bHit;

    mic1_reg_copy_fsm #(.NREGS(NREGS)) copyFsm (
        .clock      (clock),
        .reset      (reset),
        .saveReq    (bus.save_req),
        .restoreReq (bus.restore_req),
        .busy       (busy),
        .done       (bus.done),
        .idx        (idx),
        .saveStb    (saveStb),
        .restoreStb (restoreStb)
    );

    // C-bus writes only while idle; copies move one register per cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i]   <= RESET_VALUE;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (!busy && bus.wr_mask[i]) regs[i] <= bus.c_bus;
            if (restoreStb) regs[idx] <= shadow[idx];
            if (saveStb) shadow[idx] <= regs[idx];
        end
    end

    assign bus.busy = busy;
    assign bHit     = bus.b_en && (32'(bus.b_sel) < NREGS);

`ifdef MIC1_REG_BANK_TRISTATE_EN
    assign bus.b_bus = bHit ? regs[bus.b_sel] : 'z;
`else
    assign bus.b_bus = bHit ? regs[bus.b_sel] : '0;
`endif

    for (genvar g = 0; g < NREGS; g++) begin : gFlat
        assign bus.all_regs[g*WIDTH +: WIDTH] = regs[g];
    end
endmodule
